// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: load/store funct3 encodings, the arbiter state
// enum and the requester identifier used by the memory port arbiter.
package rv32_pkg;

    // RV32I load/store funct3 encodings (size and signedness)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_RDATA = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_e;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store byte enables and lane replication,
// load byte/half extraction with sign/zero extension, misalignment and
// illegal-funct3 detection.
module mem_lane_align
    import rv32_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        we_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_lane_o,
    output logic [31:0] rdata_ext_o,
    output logic        err_o
);

    logic [7:0]  lane_byte [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane_byte[gi] = rword_i[8*gi +: 8];
    end

    assign byte_sel = lane_byte[addr_lo_i];
    assign half_sel = addr_lo_i[1] ? {lane_byte[3], lane_byte[2]}
                                   : {lane_byte[1], lane_byte[0]};

    // Lane formatting and legality check for the current access
    always_comb begin
        be_o         = 4'b1111;
        wdata_lane_o = wdata_i;
        rdata_ext_o  = rword_i;
        err_o        = 1'b0;
        if (we_i) begin
            case (funct3_i)
                F3_B: begin
                    be_o         = 4'b0001 << addr_lo_i;
                    wdata_lane_o = {4{wdata_i[7:0]}};
                end
                F3_H: begin
                    be_o         = 4'b0011 << addr_lo_i;
                    wdata_lane_o = {2{wdata_i[15:0]}};
                    err_o        = addr_lo_i[0];
                end
                F3_W:    err_o = |addr_lo_i;
                default: err_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                F3_B:    rdata_ext_o = {{24{byte_sel[7]}}, byte_sel};
                F3_BU:   rdata_ext_o = {24'd0, byte_sel};
                F3_H: begin
                    rdata_ext_o = {{16{half_sel[15]}}, half_sel};
                    err_o       = addr_lo_i[0];
                end
                F3_HU: begin
                    rdata_ext_o = {16'd0, half_sel};
                    err_o       = addr_lo_i[0];
                end
                F3_W:    err_o = |addr_lo_i;
                default: err_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory bus between instruction
// fetch and load/store. One transaction in flight at a time; the winner gets
// a single-cycle done pulse with its read data or error flag.
module mem_port_arbiter
    import rv32_pkg::*;
#(
    parameter int DATA_WIDTH = 32
)
(
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  i_req,
    input  logic [DATA_WIDTH-1:0] i_addr,
    output logic                  i_done,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [2:0]            d_funct3,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_done,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_err,
    output logic                  bus_valid,
    output logic                  bus_we,
    output logic [DATA_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [3:0]            bus_be,
    input  logic                  bus_ready,
    input  logic                  bus_rvalid,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    arb_state_e            state_q, state_d;
    req_id_e               gnt_q, gnt_d;
    req_id_e               last_q, last_d;
    req_id_e               pick;
    logic [2:0]            f3_q, f3_d;
    logic [1:0]            off_q, off_d;
    logic                  we_q, we_d;
    logic                  err_q, err_d;
    logic                  bus_valid_q, bus_valid_d;
    logic                  bus_we_q, bus_we_d;
    logic [DATA_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic [2:0]            al_f3;
    logic                  al_we;
    logic [1:0]            al_off;
    logic [3:0]            lane_be;
    logic [31:0]           lane_wdata;
    logic [31:0]           lane_rdata;
    logic                  lane_err;
    logic                  unused_fetch_lo;

    // Fetch addresses are word-aligned; the low bits carry no information.
    assign unused_fetch_lo = ^i_addr[1:0];

    // Live operands while deciding a grant, sampled copies afterwards.
    assign al_f3  = (state_q == ST_IDLE) ? d_funct3    : f3_q;
    assign al_we  = (state_q == ST_IDLE) ? d_we        : we_q;
    assign al_off = (state_q == ST_IDLE) ? d_addr[1:0] : off_q;

    mem_lane_align u_align (
        .funct3_i     (al_f3),
        .we_i         (al_we),
        .addr_lo_i    (al_off),
        .wdata_i      (d_wdata),
        .rword_i      (bus_rdata),
        .be_o         (lane_be),
        .wdata_lane_o (lane_wdata),
        .rdata_ext_o  (lane_rdata),
        .err_o        (lane_err)
    );

    // Next-state: grant, bus address phase, read capture, completion
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        pick        = REQ_FETCH;
        f3_d        = f3_q;
        off_d       = off_q;
        we_d        = we_q;
        err_d       = err_q;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (en && (i_req || d_req)) begin
                    if (i_req && d_req) begin
                        pick = (last_q == REQ_DATA) ? REQ_FETCH : REQ_DATA;
                    end else begin
                        pick = i_req ? REQ_FETCH : REQ_DATA;
                    end
                    gnt_d = pick;
                    if (pick == REQ_FETCH) begin
                        we_d        = 1'b0;
                        err_d       = 1'b0;
                        bus_valid_d = 1'b1;
                        bus_we_d    = 1'b0;
                        bus_addr_d  = {i_addr[DATA_WIDTH-1:2], 2'b00};
                        bus_be_d    = 4'b1111;
                        bus_wdata_d = '0;
                        state_d     = ST_ADDR;
                    end else begin
                        f3_d  = d_funct3;
                        off_d = d_addr[1:0];
                        we_d  = d_we;
                        err_d = lane_err;
                        if (lane_err) begin
                            d_rdata_d = '0;
                            state_d   = ST_DONE;
                        end else begin
                            bus_valid_d = 1'b1;
                            bus_we_d    = d_we;
                            bus_addr_d  = {d_addr[DATA_WIDTH-1:2], 2'b00};
                            bus_be_d    = d_we ? lane_be : 4'b1111;
                            bus_wdata_d = d_we ? lane_wdata : '0;
                            state_d     = ST_ADDR;
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    bus_be_d    = 4'b0000;
                    state_d     = we_q ? ST_DONE : ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (bus_rvalid) begin
                    if (gnt_q == REQ_FETCH) begin
                        i_rdata_d = bus_rdata;
                    end else begin
                        d_rdata_d = lane_rdata;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                last_d  = gnt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            gnt_q       <= REQ_FETCH;
            last_q      <= REQ_DATA;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= 4'b0000;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            we_q        <= we_d;
            err_q       <= err_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign i_done    = (state_q == ST_DONE) && (gnt_q == REQ_FETCH);
    assign d_done    = (state_q == ST_DONE) && (gnt_q == REQ_DATA);
    assign d_err     = d_done && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random
// traffic with random bus latencies, enable gaps and resets.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn, en;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr, d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready, bus_rvalid;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_done     (i_done),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_funct3   (d_funct3),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_done     (d_done),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .bus_valid  (bus_valid),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_ready  (bus_ready),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: life of the one transaction in flight.
    // stage 0 = free, 1 = address offered, 2 = awaiting read data,
    // 3 = completion visible this cycle.
    int          stage;
    bit          last_data;
    bit          who;          // 0 fetch, 1 data
    bit          t_we, t_err, done_now;
    logic [31:0] t_addr, t_wd, t_rdata;
    logic [3:0]  t_be;
    logic [2:0]  t_f3;
    logic [1:0]  t_off;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit f_illegal(input logic [2:0] f3, input bit we, input logic [1:0] off);
        if (we) return (f3 > 3'd2) || (f3 == 3'd1 && off[0]) || (f3 == 3'd2 && off != 2'd0);
        return (f3 == 3'd3) || (f3 > 3'd5) || ((f3 == 3'd1 || f3 == 3'd5) && off[0])
               || (f3 == 3'd2 && off != 2'd0);
    endfunction

    function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [1:0] off);
        int unsigned m;
        if (f3 == 3'd0) m = 1 << off;
        else if (f3 == 3'd1) m = 3 << off;
        else m = 15;
        return m[3:0];
    endfunction

    function automatic logic [31:0] f_wlane(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
        logic [31:0] v;
        logic [31:0] b;
        logic [31:0] h;
        v = word >> (8 * off);
        b = v & 32'hFF;
        h = v & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    task automatic model_step();
        done_now = 1'b0;
        if (!rstn) begin
            stage     = 0;
            last_data = 1'b1;
            return;
        end
        case (stage)
            0: if (en && (i_req || d_req)) begin
                who = (i_req && d_req) ? ~last_data : d_req;
                if (!who) begin
                    t_we = 0; t_err = 0; t_be = 4'hF; t_wd = 0;
                    t_addr = i_addr & 32'hFFFF_FFFC;
                    stage = 1;
                end else begin
                    t_f3   = d_funct3;
                    t_off  = d_addr[1:0];
                    t_we   = d_we;
                    t_err  = f_illegal(d_funct3, d_we, d_addr[1:0]);
                    t_addr = d_addr & 32'hFFFF_FFFC;
                    t_be   = d_we ? f_be(d_funct3, d_addr[1:0]) : 4'hF;
                    t_wd   = d_we ? f_wlane(d_funct3, d_wdata) : 32'd0;
                    if (t_err) begin
                        stage = 3; done_now = 1'b1;
                    end else begin
                        stage = 1;
                    end
                end
            end
            1: if (bus_ready) begin
                if (t_we) begin
                    stage = 3; done_now = 1'b1;
                end else begin
                    stage = 2;
                end
            end
            2: if (bus_rvalid) begin
                t_rdata  = who ? f_load(t_f3, t_off, bus_rdata) : bus_rdata;
                stage    = 3;
                done_now = 1'b1;
            end
            default: begin
                last_data = who;
                stage     = 0;
            end
        endcase
    endtask

    task automatic compare();
        if (!rstn) begin
            chk("rst_bus_ctl", {26'd0, bus_valid, bus_we, bus_be}, 32'd0);
            chk("rst_bus_addr", bus_addr, 32'd0);
            chk("rst_bus_wdata", bus_wdata, 32'd0);
            chk("rst_done", {29'd0, i_done, d_done, d_err}, 32'd0);
            chk("rst_i_rdata", i_rdata, 32'd0);
            chk("rst_d_rdata", d_rdata, 32'd0);
            return;
        end
        chk("bus_valid", bus_valid, stage == 1);
        if (stage == 1) begin
            chk("bus_we", bus_we, t_we);
            chk("bus_addr", bus_addr, t_addr);
            chk("bus_be", bus_be, t_be);
            chk("bus_wdata", bus_wdata, t_wd);
        end
        chk("i_done", i_done, done_now && !who);
        chk("d_done", d_done, done_now && who);
        if (done_now && !who) chk("i_rdata", i_rdata, t_rdata);
        if (done_now && who) begin
            chk("d_err", d_err, t_err);
            if (!t_err && !t_we) chk("d_rdata", d_rdata, t_rdata);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        compare();
    endtask

    task automatic quiet_inputs();
        i_req = 0; d_req = 0; bus_ready = 0; bus_rvalid = 0; en = 1;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rstn = 0;
        step();
        step();
        rstn = 1;
        step();
    endtask

    // Directed data-side access: ready always high, rvalid from cycle 2.
    task automatic run_d(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rword,
                         output int cyc, output logic [31:0] rd, output logic err,
                         output logic [3:0] be, output logic [31:0] bwd, output bit saw_valid);
        d_req = 1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wd;
        bus_ready = 1; bus_rvalid = 0; bus_rdata = rword;
        cyc = -1; rd = 0; err = 0; be = 0; bwd = 0; saw_valid = 0;
        for (int k = 1; k <= 12 && cyc < 0; k++) begin
            step();
            if (bus_valid) begin
                saw_valid = 1; be = bus_be; bwd = bus_wdata;
            end
            if (k == 2) bus_rvalid = 1;
            if (d_done) begin
                cyc = k; rd = d_rdata; err = d_err;
            end
        end
        quiet_inputs();
        step();
    endtask

    initial begin
        int          cyc, order, ndone, nboth, cnt;
        logic [31:0] rd, bwd, seen_addr;
        logic        err;
        logic [3:0]  be;
        bit          saw;

        rstn = 0; en = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_funct3 = 0;
        d_addr = 0; d_wdata = 0; bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
        stage = 0; last_data = 1; who = 0; done_now = 0;

        // Model pinned against hand-computed values
        chk("model_lb", f_load(3'd0, 2'd3, 32'h80FF_1234), 32'hFFFF_FF80);
        chk("model_lh", f_load(3'd1, 2'd2, 32'h80FF_1234), 32'hFFFF_80FF);
        chk("model_sb_lane", f_wlane(3'd0, 32'h0000_00AB), 32'hABAB_ABAB);
        chk("model_sh_be", f_be(3'd1, 2'd2), 32'h0000_000C);

        do_reset();

        // Fetch alone
        i_req = 1; i_addr = 32'h100; bus_ready = 1; bus_rvalid = 0; bus_rdata = 32'hDEAD_BEEF;
        cyc = -1; seen_addr = 0; rd = 0;
        for (int k = 1; k <= 10 && cyc < 0; k++) begin
            step();
            if (bus_valid) seen_addr = bus_addr;
            if (k == 2) bus_rvalid = 1;
            if (i_done) begin
                cyc = k; rd = i_rdata;
            end
        end
        quiet_inputs();
        step();
        chk("fetch_cycle", cyc, 3);
        chk("fetch_addr", seen_addr, 32'h100);
        chk("fetch_rdata", rd, 32'hDEAD_BEEF);

        run_d(0, 3'd0, 32'h203, 0, 32'h80FF_1234, cyc, rd, err, be, bwd, saw);
        chk("lb_cycle", cyc, 3);
        chk("lb_data", rd, 32'hFFFF_FF80);
        run_d(0, 3'd4, 32'h203, 0, 32'h80FF_1234, cyc, rd, err, be, bwd, saw);
        chk("lbu_data", rd, 32'h0000_0080);
        run_d(0, 3'd1, 32'h202, 0, 32'h80FF_1234, cyc, rd, err, be, bwd, saw);
        chk("lh_data", rd, 32'hFFFF_80FF);
        run_d(1, 3'd0, 32'h201, 32'hAB, 0, cyc, rd, err, be, bwd, saw);
        chk("sb_cycle", cyc, 2);
        chk("sb_be", be, 4'b0010);
        chk("sb_wdata", bwd, 32'hABAB_ABAB);
        run_d(1, 3'd1, 32'h202, 32'h1234, 0, cyc, rd, err, be, bwd, saw);
        chk("sh_be", be, 4'b1100);
        run_d(0, 3'd2, 32'h102, 0, 0, cyc, rd, err, be, bwd, saw);
        chk("lw_mis_cycle", cyc, 1);
        chk("lw_mis_err", err, 1);
        chk("lw_mis_nobus", saw, 0);
        run_d(0, 3'd3, 32'h100, 0, 0, cyc, rd, err, be, bwd, saw);
        chk("f3_3_err", err, 1);

        // Contention: both held for three transactions
        do_reset();
        i_req = 1; i_addr = 32'h40; d_req = 1; d_we = 0; d_funct3 = 3'd2; d_addr = 32'h300;
        bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'h1357_9BDF;
        order = 0; ndone = 0; nboth = 0;
        for (int k = 0; k < 40 && ndone < 3; k++) begin
            step();
            if (i_done && d_done) nboth++;
            if (i_done) begin order = order * 10 + 1; ndone++; end
            else if (d_done) begin order = order * 10 + 2; ndone++; end
        end
        quiet_inputs();
        step();
        chk("contention_order", order, 121);
        chk("contention_overlap", nboth, 0);

        // Stall: ready low keeps address phase stable
        d_req = 1; d_we = 1; d_funct3 = 3'd2; d_addr = 32'h400; d_wdata = 32'h1122_3344;
        bus_ready = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("stall_addr", bus_addr, 32'h400);
            chk("stall_wdata", bus_wdata, 32'h1122_3344);
            chk("stall_valid", bus_valid, 1);
        end
        bus_ready = 1;
        step();
        chk("stall_done", d_done, 1);
        quiet_inputs();
        step();

        // Reset while waiting for read data
        d_req = 1; d_we = 0; d_funct3 = 3'd2; d_addr = 32'h500; bus_ready = 1; bus_rvalid = 0;
        step();
        step();
        rstn = 0; d_req = 0; bus_ready = 0;
        step();
        rstn = 1; bus_rvalid = 1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (i_done || d_done) cnt++;
        end
        chk("rst_drop_no_done", cnt, 0);
        quiet_inputs();

        // Random traffic
        do_reset();
        ndone = 0;
        for (int k = 0; k < 4000; k++) begin
            step();
            if (i_done || d_done) ndone++;
            if (i_done) i_req = 0;
            if (d_done) d_req = 0;
            if (!i_req && $urandom_range(0, 3) == 0) begin
                i_req = 1;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1;
                d_we = $urandom_range(0, 1);
                d_funct3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                         : 3'($urandom_range(0, 2) | ($urandom_range(0, 1) << 2));
                d_addr = $urandom;
                if ($urandom_range(0, 2) != 0) d_addr[1:0] = 2'd0;
                d_wdata = $urandom;
            end
            en         = ($urandom_range(0, 7) != 0);
            bus_ready  = ($urandom_range(0, 2) != 0);
            bus_rvalid = $urandom_range(0, 1);
            bus_rdata  = $urandom;
            rstn       = ($urandom_range(0, 299) != 0);
        end
        rstn = 1;
        chk("random_activity", ndone > 100, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing the single-cycle RV32 core's one memory bus between instruction fetch and load/store. It round-robins between requesters, runs a single-outstanding valid/ready bus transaction, formats store byte lanes and extracts load data per funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW). It pulses a completion strobe back to the winning requester; the core stalls on it.

## Interface
- DATA_WIDTH, 32, data/address width; only 32 is supported.
- clk  in  1  rising-edge clock
- rstn  in  1  reset, synchronous, active-low
- en  in  1  grant enable; low blocks new grants, in-flight transfer completes
- i_req  in  1  fetch request, held until i_done
- i_addr  in  32  fetch address, word-aligned
- i_done  out  1  one-cycle fetch completion pulse
- i_rdata  out  32  fetched word, valid with i_done
- d_req  in  1  load/store request, held with its operands until d_done
- d_we  in  1  1 = store, 0 = load
- d_funct3  in  3  access size/sign (RV32I load/store encoding)
- d_addr  in  32  byte address
- d_wdata  in  32  store data, right-justified
- d_done  out  1  one-cycle completion pulse
- d_rdata  out  32  extended load data, valid with d_done
- d_err  out  1  misaligned or illegal funct3, valid with d_done
- bus_valid  out  1  address phase valid
- bus_we  out  1  write strobe
- bus_addr  out  32  word address ({addr[31:2],2'b00})
- bus_wdata  out  32  lane-replicated store data
- bus_be  out  4  byte enables
- bus_ready  in  1  address phase accepted
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read word

## Operation
- FSM states: IDLE, ADDR, RDATA, DONE.
- IDLE: if en and any req → grant. Both requesting → grant the side not granted last (last_gnt register, resets to data, so fetch wins first tie). Sample the winner's operands into registers.
- Misaligned data (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0) or funct3 in {3,6,7} for loads, ≥3 for stores: IDLE → DONE, d_err=1, no bus cycle.
- ADDR: bus_valid=1 with registered outputs held stable until bus_ready. Ready on a write → DONE; on a read → RDATA.
- RDATA: wait for bus_rvalid; capture and format data → DONE.
- DONE: one cycle; raise the winner's done (plus rdata/err); update last_gnt → IDLE. Requests are not sampled in DONE.
- Store lanes: SB → be=0001<<addr[1:0], wdata={4{b}}; SH → be=0011<<addr[1:0] (addr[1]∈{0,1}), wdata={2{h}}; SW → be=1111.
- Load extract: select the byte/half by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Fetch: bus_be=1111, bus_we=0, raw word.
- bus_rvalid outside RDATA is ignored. bus_ready outside ADDR is ignored.
- en low in ADDR/RDATA does not abort.

## Timing
- Reset: state=IDLE, last_gnt=data, all outputs 0 (bus_valid, bus_we, bus_be, bus_addr, bus_wdata, i_done, d_done, d_err, i_rdata, d_rdata).
- Reset mid-transfer: immediate return to IDLE; a pending bus response is dropped, no done pulse.
- Minimum read: req cycle 0 (IDLE), bus_valid+ready cycle 1, rvalid cycle 2, done cycle 3.
- Minimum write: done cycle 2. Error: done cycle 1.
- Back-to-back: next grant at the earliest in the cycle after DONE; sustained throughput is 1 read per 4 cycles.
- done is a single-cycle pulse; exactly one of i_done/d_done per transaction.

## Structure
- rv32_pkg holds the funct3 constants (F3_B/H/W/BU/HU), the state enum and the requester id; control_unit imports the same funct3 constants.
- Sub-module mem_lane_align (combinational): store be/wdata generation, load extraction and the misalignment check. The arbiter FSM holds all state.

## Test plan
- Fetch alone: i_addr=0x100, bus_rdata=0xDEADBEEF, rvalid 1 cycle after ready → bus_addr=0x100, be=1111, i_done cycle 3, i_rdata=0xDEADBEEF.
- Loads: addr=0x203, word 0x80FF_1234 → LB gives d_rdata=0xFFFFFF80, LBU gives 0x00000080. LH at 0x202 → 0xFFFF80FF.
- Stores: SB at 0x201, wdata=0xAB → be=0010, bus_wdata=0xABABABAB, d_done cycle 2. SH at 0x202 → be=1100.
- Contention: i_req and d_req held together for 3 transactions → grant order fetch, data, fetch. No done pulse overlaps.
- Errors: LW at 0x102 → d_err=1 with d_done cycle 1, bus_valid never asserted. Load funct3=3 → d_err=1.
- Stalls/reset: bus_ready low for 5 cycles → bus outputs stable throughout. rstn low while in RDATA → IDLE with outputs 0, and a later rvalid produces no done pulse.
